// File: rtl/lsu_ram_master_pkg.sv
// Shared types and helpers for the load/store RAM initiator: op codes,
// FSM state encoding and exception codes seen by the consumer.
package lsu_ram_master_pkg;

   typedef enum logic [2:0] {
      LSU_LB  = 3'd0,
      LSU_LBU = 3'd1,
      LSU_LH  = 3'd2,
      LSU_LHU = 3'd3,
      LSU_LW  = 3'd4,
      LSU_SB  = 3'd5,
      LSU_SH  = 3'd6,
      LSU_SW  = 3'd7
   } lsu_op_e;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_RESP   = 2'd2
   } lsu_state_e;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;

   function automatic logic op_is_store(lsu_op_e op);
      return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
   endfunction

   function automatic logic op_misaligned(lsu_op_e op, logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (op)
         LSU_LH, LSU_LHU, LSU_SH: mis = addr_lo[0];
         LSU_LW, LSU_SW:          mis = (addr_lo != 2'b00);
         default:                 mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane handling for both directions: store lane select plus replicated
// data, and load byte/half extraction with sign or zero extension.
module lsu_lane_align
   import lsu_ram_master_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  wsel,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   lsu_op_e     op_e;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign op_e = lsu_op_e'(op);

   always_comb begin
      wsel      = 4'b0000;
      wdata_rep = 32'h0;
      case (op_e)
         LSU_SB: begin
            wsel      = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         LSU_SH: begin
            wsel      = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         LSU_SW: begin
            wsel      = 4'b1111;
            wdata_rep = wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_v = rdata_raw[7:0];
      case (addr_lo)
         2'd1:    byte_v = rdata_raw[15:8];
         2'd2:    byte_v = rdata_raw[23:16];
         2'd3:    byte_v = rdata_raw[31:24];
         default: byte_v = rdata_raw[7:0];
      endcase
   end

   assign half_v = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

   // Store ops return zero so the response path needs no extra gating.
   always_comb begin
      rdata_ext = 32'h0;
      case (op_e)
         LSU_LB:  rdata_ext = {{24{byte_v[7]}}, byte_v};
         LSU_LBU: rdata_ext = {24'h0, byte_v};
         LSU_LH:  rdata_ext = {{16{half_v[15]}}, half_v};
         LSU_LHU: rdata_ext = {16'h0, half_v};
         LSU_LW:  rdata_ext = rdata_raw;
         default: rdata_ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_ram_master.sv
// Load/store initiator between the MEM stage and the byte-lane data RAM.
//
// state      | meaning
// LSU_IDLE   | ready for a request; alignment checked on accept
// LSU_ACCESS | RAM signals driven for 1+ACCESS_WAIT cycles, load word sampled on last
// LSU_RESP   | response held until the consumer takes it
module lsu_ram_master
   import lsu_ram_master_pkg::*;
#(
   parameter int unsigned ACCESS_WAIT = 0
)
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  req_op_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_adel_o,
   output logic        resp_ades_o,
   output logic [31:0] resp_badvaddr_o,
   output logic        ram_write_enable_o,
   output logic [3:0]  ram_write_select_o,
   output logic [31:0] ram_write_addr_o,
   output logic [31:0] ram_write_data_o,
   output logic [31:0] ram_read_addr_o,
   input  logic [31:0] ram_read_data_i
);

   localparam logic [2:0] WAIT_INIT = 3'(ACCESS_WAIT);

   lsu_state_e  state_q, state_d;
   lsu_op_e     op_q;
   lsu_op_e     req_op;
   logic [1:0]  addr_lo_q;
   logic [31:0] wdata_q;
   logic [29:0] word_addr_q;
   logic [2:0]  wait_cnt_q;
   logic [31:0] rdata_q;
   logic [31:0] badvaddr_q;
   logic        adel_q;
   logic        ades_q;

   logic        req_fire;
   logic        resp_fire;
   logic        req_misaligned;
   logic        access_done;
   logic        store_access;
   logic [3:0]  lane_sel;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;

   assign req_op         = lsu_op_e'(req_op_i);
   assign req_fire       = req_valid_i && (state_q == LSU_IDLE);
   assign resp_fire      = resp_ready_i && (state_q == LSU_RESP);
   assign req_misaligned = op_misaligned(req_op, req_addr_i[1:0]);
   assign access_done    = (wait_cnt_q == 3'd0);
   assign store_access   = (state_q == LSU_ACCESS) && op_is_store(op_q);

   lsu_lane_align u_lane_align (
      .op        (op_q),
      .addr_lo   (addr_lo_q),
      .wdata     (wdata_q),
      .rdata_raw (ram_read_data_i),
      .wsel      (lane_sel),
      .wdata_rep (lane_wdata),
      .rdata_ext (lane_rdata)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= LSU_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE:   if (req_fire) state_d = req_misaligned ? LSU_RESP : LSU_ACCESS;
         LSU_ACCESS: if (access_done) state_d = LSU_RESP;
         LSU_RESP:   if (resp_fire) state_d = LSU_IDLE;
         default:    state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         op_q        <= LSU_LB;
         addr_lo_q   <= 2'b00;
         wdata_q     <= 32'h0;
         word_addr_q <= 30'h0;
         wait_cnt_q  <= 3'd0;
         rdata_q     <= 32'h0;
         badvaddr_q  <= 32'h0;
         adel_q      <= 1'b0;
         ades_q      <= 1'b0;
      end else begin
         if (req_fire) begin
            op_q      <= req_op;
            addr_lo_q <= req_addr_i[1:0];
            wdata_q   <= req_wdata_i;
            if (req_misaligned) begin
               // Faults skip the RAM entirely; the word address keeps its old value.
               adel_q     <= !op_is_store(req_op);
               ades_q     <= op_is_store(req_op);
               badvaddr_q <= req_addr_i;
               rdata_q    <= 32'h0;
            end else begin
               word_addr_q <= req_addr_i[31:2];
               wait_cnt_q  <= WAIT_INIT;
            end
         end
         if (state_q == LSU_ACCESS) begin
            if (access_done) rdata_q    <= lane_rdata;
            else             wait_cnt_q <= wait_cnt_q - 3'd1;
         end
         if (resp_fire) begin
            rdata_q    <= 32'h0;
            badvaddr_q <= 32'h0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
         end
      end
   end

   assign req_ready_o        = (state_q == LSU_IDLE);
   assign resp_valid_o       = (state_q == LSU_RESP);
   assign resp_rdata_o       = rdata_q;
   assign resp_adel_o        = adel_q;
   assign resp_ades_o        = ades_q;
   assign resp_badvaddr_o    = badvaddr_q;
   assign ram_write_enable_o = store_access;
   assign ram_write_select_o = store_access ? lane_sel : 4'b0000;
   assign ram_write_data_o   = store_access ? lane_wdata : 32'h0;
   assign ram_write_addr_o   = {word_addr_q, 2'b00};
   assign ram_read_addr_o    = {word_addr_q, 2'b00};

endmodule

// File: tb/tb_lsu_ram_master.sv
// Scoreboard bench for lsu_ram_master: directed loads/stores against a
// behavioural byte-lane RAM, plus a mid-access reset on a slow instance.
`timescale 1ns/1ps
module tb_lsu_ram_master;
   import lsu_ram_master_pkg::*;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic        aresetn, req_valid, req_ready, resp_valid, resp_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata, resp_rdata, resp_badv;
   logic        resp_adel, resp_ades, ram_we;
   logic [3:0]  ram_sel;
   logic [31:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;

   logic        rst3_n, r_valid, r_ready, r_resp_valid, r_resp_ready;
   logic [2:0]  r_op;
   logic [31:0] r_addr, r_wd, r_resp_rdata, r_resp_badv;
   logic        r_resp_adel, r_resp_ades, r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_waddr, r_wdata, r_raddr, r_rdata;

   lsu_ram_master #(.ACCESS_WAIT(0)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
      .resp_adel_o(resp_adel), .resp_ades_o(resp_ades), .resp_badvaddr_o(resp_badv),
      .ram_write_enable_o(ram_we), .ram_write_select_o(ram_sel),
      .ram_write_addr_o(ram_waddr), .ram_write_data_o(ram_wdata),
      .ram_read_addr_o(ram_raddr), .ram_read_data_i(ram_rdata)
   );

   lsu_ram_master #(.ACCESS_WAIT(3)) u_dut3 (
      .aclk(aclk), .aresetn(rst3_n),
      .req_valid_i(r_valid), .req_ready_o(r_ready), .req_op_i(r_op),
      .req_addr_i(r_addr), .req_wdata_i(r_wd),
      .resp_valid_o(r_resp_valid), .resp_ready_i(r_resp_ready), .resp_rdata_o(r_resp_rdata),
      .resp_adel_o(r_resp_adel), .resp_ades_o(r_resp_ades), .resp_badvaddr_o(r_resp_badv),
      .ram_write_enable_o(r_we), .ram_write_select_o(r_sel),
      .ram_write_addr_o(r_waddr), .ram_write_data_o(r_wdata),
      .ram_read_addr_o(r_raddr), .ram_read_data_i(r_rdata)
   );

   logic [31:0] mem [0:1023];
   assign ram_rdata = mem[ram_raddr[11:2]];
   always @(posedge aclk)
      if (ram_we)
         for (int i = 0; i < 4; i++)
            if (ram_sel[i]) mem[ram_waddr[11:2]][8*i +: 8] <= ram_wdata[8*i +: 8];

   typedef struct {
      logic [31:0] rdata;
      logic        adel;
      logic        ades;
      logic [31:0] badv;
      int          first;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   always @(posedge aclk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: latency on the first response cycle, payload on handshake.
   always @(negedge aclk) begin
      if (resp_valid && !prev_valid) begin
         if (exp_q.size() == 0) chk("resp_unexpected", exp_q.size(), 1);
         else                   chk("resp_latency", cyc, exp_q[0].first);
      end
      if (resp_valid && resp_ready && exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("resp_rdata", resp_rdata, mon_e.rdata);
         chk("resp_adel", resp_adel, mon_e.adel);
         chk("resp_ades", resp_ades, mon_e.ades);
         chk("resp_badv", resp_badv, mon_e.badv);
      end
      prev_valid = resp_valid;
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic [3:0] exp_sel,
                        input logic [31:0] exp_wd, input bit fault, input bit wait_done);
      exp_t e;
      int   n;
      bit   st;
      st = (op >= 3'd5);
      @(negedge aclk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      chk("accept_timeout", 32'(n < 50), 1);
      @(posedge aclk); #1;
      e.rdata = fault ? 32'h0 : exp_rd;
      e.adel  = fault && !st;
      e.ades  = fault && st;
      e.badv  = fault ? addr : 32'h0;
      e.first = cyc + (fault ? 0 : 1);
      exp_q.push_back(e);
      req_valid = 1'b0;
      @(negedge aclk);
      if (fault) begin
         chk("fault_we", ram_we, 0);
         chk("fault_sel", ram_sel, 0);
      end else begin
         chk("acc_we", ram_we, st);
         chk("acc_sel", ram_sel, exp_sel);
         chk("acc_raddr", ram_raddr, {addr[31:2], 2'b00});
         chk("acc_waddr", ram_waddr, {addr[31:2], 2'b00});
         if (st) chk("acc_wdata", ram_wdata, exp_wd);
      end
      if (wait_done) begin
         n = 0;
         while (exp_q.size() != 0 && n < 50) begin @(negedge aclk); n++; end
         chk("resp_timeout", 32'(n < 50), 1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[4] = 32'h1122_3344;
      aresetn = 1'b0; rst3_n = 1'b0;
      req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
      r_valid = 1'b0; r_op = 3'd0; r_addr = 32'h0; r_wd = 32'h0; r_resp_ready = 1'b1; r_rdata = 32'h0;
      @(negedge aclk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_sel", ram_sel, 0);
      chk("rst_raddr", ram_raddr, 0);
      chk("rst_rdata", resp_rdata, 0);
      @(negedge aclk);
      aresetn = 1'b1; rst3_n = 1'b1;
      @(negedge aclk);

      issue(LSU_SB,  32'h13, 32'h0000_00A5, 32'h0,         4'b1000, 32'hA5A5_A5A5, 0, 1);
      issue(LSU_LB,  32'h13, 32'h0,         32'hFFFF_FFA5, 4'b0000, 32'h0,         0, 1);
      issue(LSU_LBU, 32'h13, 32'h0,         32'h0000_00A5, 4'b0000, 32'h0,         0, 1);
      issue(LSU_LW,  32'h10, 32'h0,         32'hA522_3344, 4'b0000, 32'h0,         0, 1);
      issue(LSU_SW,  32'h10, 32'hDEAD_BEEF, 32'h0,         4'b1111, 32'hDEAD_BEEF, 0, 1);
      issue(LSU_LW,  32'h10, 32'h0,         32'hDEAD_BEEF, 4'b0000, 32'h0,         0, 1);
      issue(LSU_SH,  32'h22, 32'h0000_8001, 32'h0,         4'b1100, 32'h8001_8001, 0, 1);
      issue(LSU_LH,  32'h22, 32'h0,         32'hFFFF_8001, 4'b0000, 32'h0,         0, 1);
      issue(LSU_LHU, 32'h22, 32'h0,         32'h0000_8001, 4'b0000, 32'h0,         0, 1);
      issue(LSU_LW,  32'h20, 32'h0,         32'h8001_0000, 4'b0000, 32'h0,         0, 1);
      issue(LSU_SB,  32'h01, 32'h0000_007F, 32'h0,         4'b0010, 32'h7F7F_7F7F, 0, 1);
      issue(LSU_LB,  32'h01, 32'h0,         32'h0000_007F, 4'b0000, 32'h0,         0, 1);
      issue(LSU_LH,  32'h00, 32'h0,         32'h0000_7F00, 4'b0000, 32'h0,         0, 1);
      issue(LSU_LW,  32'h06, 32'h0,         32'h0,         4'b0000, 32'h0,         1, 1);
      issue(LSU_SH,  32'h05, 32'h1234_5678, 32'h0,         4'b0000, 32'h0,         1, 1);
      issue(LSU_LH,  32'h03, 32'h0,         32'h0,         4'b0000, 32'h0,         1, 1);

      // Back-pressure: response must hold while a new request waits.
      resp_ready = 1'b0;
      issue(LSU_LBU, 32'h13, 32'h0, 32'h0000_00DE, 4'b0000, 32'h0, 0, 0);
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
      chk("stall_resp_timeout", 32'(n < 20), 1);
      req_valid = 1'b1; req_op = LSU_LW; req_addr = 32'h10;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", resp_valid, 1);
         chk("stall_rdata", resp_rdata, 32'h0000_00DE);
         chk("stall_req_ready", req_ready, 0);
         @(negedge aclk);
      end
      @(posedge aclk); #1;
      resp_ready = 1'b1;
      issue(LSU_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 0, 1);
      chk("scoreboard_empty", exp_q.size(), 0);

      // Reset during a store access on the ACCESS_WAIT=3 instance.
      @(negedge aclk);
      r_valid = 1'b1; r_op = LSU_SW; r_addr = 32'h40; r_wd = 32'h1234_5678;
      n = 0;
      while (r_ready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
      @(posedge aclk); #1;
      r_valid = 1'b0;
      @(negedge aclk);
      chk("slow_we_before", r_we, 1);
      chk("slow_sel_before", r_sel, 4'b1111);
      @(negedge aclk);
      chk("slow_we_hold", r_we, 1);
      #2 rst3_n = 1'b0;
      #1;
      chk("slow_we_async", r_we, 0);
      chk("slow_sel_async", r_sel, 0);
      chk("slow_ready_rst", r_ready, 1);
      @(negedge aclk);
      rst3_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         chk("slow_no_resp", r_resp_valid, 0);
         chk("slow_ready_after", r_ready, 1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lsu_ram_master.md
Name: lsu_ram_master

Overview:
- Load/store initiator that sits between the MEM pipeline stage and the 4 KB byte-lane data RAM.
- Accepts one load/store request per handshake and checks address alignment.
- Drives the RAM's word address, byte-lane write select and write enable. Replicates store data across lanes.
- Samples the RAM's combinational read word, then extracts and sign/zero-extends the addressed byte or halfword before returning it on a response handshake.

Parameters:
- ACCESS_WAIT, 0, extra cycles the ACCESS state holds RAM signals stable before completing; range 0..7.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_op_i  in  3  operation: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data; low byte/half used for SB/SH
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumer ready
- resp_rdata_o  out  32  extended load result; 0 for stores and faults
- resp_adel_o  out  1  load address error (misaligned)
- resp_ades_o  out  1  store address error (misaligned)
- resp_badvaddr_o  out  32  faulting byte address; 0 when no fault
- ram_write_enable_o  out  1  RAM write strobe
- ram_write_select_o  out  4  byte-lane select; bit i = bits [8i+7:8i]
- ram_write_addr_o  out  32  RAM write address, word-aligned
- ram_write_data_o  out  32  lane-replicated store data
- ram_read_addr_o  out  32  RAM read address, word-aligned
- ram_read_data_i  in  32  RAM combinational read word

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (aresetn low, asynchronous):
  - state=IDLE; all outputs 0 except req_ready_o=1.
  - ram_write_enable_o falls immediately, even mid-ACCESS. The in-flight request is discarded with no response.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o, register op, addr and wdata.
  - Misaligned requests go to RESP with a fault and produce no RAM activity. Misaligned means: halfword ops with addr[0]=1, or word ops with addr[1:0]!=0.
  - Aligned requests go to ACCESS.
- ACCESS (1+ACCESS_WAIT cycles, counted by a 3-bit counter):
  - ram_read_addr_o = ram_write_addr_o = {addr[31:2],2'b00}.
  - Stores drive ram_write_enable_o=1 for every ACCESS cycle, with select and data constant throughout.
  - Lane select and data by op:
    - SB: select = 4'b0001<<addr[1:0]; data = {4{wdata[7:0]}}.
    - SH: select = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
    - SW: select = 4'b1111; data = wdata.
  - Loads keep ram_write_enable_o=0 and ram_write_select_o=0.
  - On the last ACCESS cycle, the load result is captured from ram_read_data_i:
    - LB/LBU: byte at lane addr[1:0], sign/zero-extended.
    - LH/LHU: half at addr[1], sign/zero-extended.
    - LW: whole word.
  - The block then goes to RESP.
- RESP:
  - resp_valid_o=1, with rdata, adel, ades and badvaddr held stable until resp_ready_i.
  - On handshake go to IDLE, and clear resp_* outputs to 0 on that edge.
  - req_ready_o=0 in ACCESS and RESP.
- Outside ACCESS: ram_write_enable_o=0 and ram_write_select_o=0. RAM addresses hold the last registered word address (0 after reset).
- Latency: request handshake at edge N. resp_valid_o first high in cycle N+2+ACCESS_WAIT for aligned requests, and cycle N+1 for faults.
- Throughput: at most one request per 3+ACCESS_WAIT cycles. There is no request/response overlap.
- Unused op encodings do not exist; all 3-bit values are defined.

Decomposition:
- Shared header defines.vh gains:
  - op-code constants LSU_LB..LSU_SW;
  - state encodings LSU_IDLE/LSU_ACCESS/LSU_RESP;
  - exception codes ADEL=5'h04, ADES=5'h05 for the consumer.
- One combinational sub-module, lsu_lane_align, covers both directions of lane handling:
  - store side: op+addr[1:0]+wdata -> select+replicated data;
  - load side: op+addr[1:0]+raw word -> extended result.

Test Plan:
- SW addr 0x0000_0010 data 0xDEADBEEF, then LW 0x10 -> one ACCESS cycle with enable=1, select=4'b1111; load response rdata=0xDEADBEEF, resp_valid two cycles after accept.
- SB 0x13 data 0x000000A5 over word 0x11223344, then LB 0x13 and LBU 0x13 -> select=4'b1000, write data 0xA5A5A5A5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5; word becomes 0xA5223344.
- SH 0x22 data 0x00008001, then LH 0x22 / LHU 0x22 -> select=4'b1100; LH returns 0xFFFF8001, LHU returns 0x00008001.
- LW 0x0000_0006 and SH 0x0000_0005 -> no RAM enable at any cycle; response next cycle with adel=1 / ades=1 respectively, badvaddr=0x6 / 0x5, rdata=0.
- resp_ready_i held low 5 cycles after a load -> resp_valid_o and rdata stable all 5 cycles, req_ready_o=0; a req_valid_i presented meanwhile is not accepted until IDLE.
- aresetn pulsed low during ACCESS of an SW, with ACCESS_WAIT=3 -> ram_write_enable_o drops in the same cycle, no response appears, and req_ready_o=1 after release.
